// File: rtl/bias_add_instr_issuer_if.sv
// Host command/response, accelerator instruction and writeback channels of the bias-add issuer.
// The issuer takes the slave view; the host/accelerator environment takes the master view.
interface bias_add_instr_issuer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_rs1;
    logic [31:0] cmd_rs2;
    logic [4:0]  cmd_rd;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_addr;

    logic        rd_we;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_wdata;

    logic        busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd,
        input  rsp_ready, instr_ready, rd_we, rd_waddr, rd_wdata,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
        output instr_valid, instr, rs1_val, rs2_val, rd_addr, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd,
        output rsp_ready, instr_ready, rd_we, rd_waddr, rd_wdata,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
        input  instr_valid, instr, rs1_val, rs2_val, rd_addr, busy
    );
endinterface

// File: rtl/bias_add_instr_issuer.sv
// Turns host commands into custom accelerator instructions, waits for register writebacks
// where the op needs one, and returns exactly one response per accepted command.
module bias_add_instr_issuer #(
    parameter int WB_TIMEOUT = 64,
    parameter int POLL_MAX   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    bias_add_instr_issuer_if.slave bus
);
    localparam int TO_W = $clog2(WB_TIMEOUT + 1);
    localparam int PC_W = $clog2(POLL_MAX + 1);

    localparam logic [2:0] OP_START = 3'd2;
    localparam logic [2:0] OP_POLL  = 3'd5;
    localparam logic [6:0] FUNCT7   = 7'h04;
    localparam logic [6:0] OPCODE   = 7'h33;
    localparam logic [31:0] TIMEOUT_TAG = 32'hDEAD_0000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_WB, RESP} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  op_reg, op_next;
    logic [31:0] rs1_reg, rs1_next;
    logic [31:0] rs2_reg, rs2_next;
    logic [4:0]  rd_reg, rd_next;
    logic [31:0] instr_reg, instr_next;
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic [PC_W-1:0] poll_cnt_reg, poll_cnt_next;
    logic [31:0] rsp_data_reg, rsp_data_next;
    logic        rsp_err_reg, rsp_err_next;

    logic            wb_hit;
    logic [TO_W-1:0] to_inc;
    logic [PC_W-1:0] poll_inc;

    // POLL is issued as a STAT instruction, so it shares the STAT funct3.
    function automatic logic [31:0] encode(input logic [2:0] op, input logic [4:0] rd);
        logic [2:0] funct3;
        funct3 = (op == OP_POLL) ? 3'b100 : op;
        return {FUNCT7, 10'd0, funct3, rd, OPCODE};
    endfunction

    assign wb_hit   = bus.rd_we && (bus.rd_waddr == rd_reg);
    assign to_inc   = to_cnt_reg + TO_W'(1);
    assign poll_inc = poll_cnt_reg + PC_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            op_reg       <= '0;
            rs1_reg      <= '0;
            rs2_reg      <= '0;
            rd_reg       <= '0;
            instr_reg    <= '0;
            to_cnt_reg   <= '0;
            poll_cnt_reg <= '0;
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            op_reg       <= op_next;
            rs1_reg      <= rs1_next;
            rs2_reg      <= rs2_next;
            rd_reg       <= rd_next;
            instr_reg    <= instr_next;
            to_cnt_reg   <= to_cnt_next;
            poll_cnt_reg <= poll_cnt_next;
            rsp_data_reg <= rsp_data_next;
            rsp_err_reg  <= rsp_err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        rs1_next      = rs1_reg;
        rs2_next      = rs2_reg;
        rd_next       = rd_reg;
        instr_next    = instr_reg;
        to_cnt_next   = to_cnt_reg;
        poll_cnt_next = poll_cnt_reg;
        rsp_data_next = rsp_data_reg;
        rsp_err_next  = rsp_err_reg;

        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid) begin
                    op_next       = bus.cmd_op;
                    rs1_next      = bus.cmd_rs1;
                    rs2_next      = bus.cmd_rs2;
                    rd_next       = bus.cmd_rd;
                    poll_cnt_next = '0;
                    to_cnt_next   = '0;
                    if (bus.cmd_op > OP_POLL) begin
                        instr_next    = '0;
                        rsp_data_next = '0;
                        rsp_err_next  = 1'b1;
                        state_next    = RESP;
                    end else begin
                        instr_next = encode(bus.cmd_op, bus.cmd_rd);
                        state_next = ISSUE;
                    end
                end
            end

            ISSUE: begin
                if (bus.instr_ready) begin
                    if (op_reg <= OP_START) begin
                        rsp_data_next = '0;
                        rsp_err_next  = 1'b0;
                        state_next    = RESP;
                    end else begin
                        to_cnt_next = '0;
                        state_next  = WAIT_WB;
                    end
                end
            end

            WAIT_WB: begin
                // An accepted writeback wins over a timeout expiring in the same cycle.
                if (wb_hit) begin
                    if (op_reg == OP_POLL && !bus.rd_wdata[1]) begin
                        poll_cnt_next = poll_inc;
                        if (poll_inc == PC_W'(POLL_MAX)) begin
                            rsp_data_next = bus.rd_wdata;
                            rsp_err_next  = 1'b1;
                            state_next    = RESP;
                        end else begin
                            state_next = ISSUE;
                        end
                    end else begin
                        rsp_data_next = bus.rd_wdata;
                        rsp_err_next  = 1'b0;
                        state_next    = RESP;
                    end
                end else begin
                    to_cnt_next = to_inc;
                    if (to_inc == TO_W'(WB_TIMEOUT)) begin
                        rsp_data_next = TIMEOUT_TAG | {29'd0, op_reg};
                        rsp_err_next  = 1'b1;
                        state_next    = RESP;
                    end
                end
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign bus.cmd_ready   = (state_reg == IDLE);
    assign bus.busy        = (state_reg != IDLE);
    assign bus.instr_valid = (state_reg == ISSUE);
    assign bus.instr       = instr_reg;
    assign bus.rs1_val     = rs1_reg;
    assign bus.rs2_val     = rs2_reg;
    assign bus.rd_addr     = rd_reg;
    assign bus.rsp_valid   = (state_reg == RESP);
    assign bus.rsp_data    = rsp_data_reg;
    assign bus.rsp_err     = rsp_err_reg;
endmodule
